// File: rtl/io_pkg.sv
// Shared types and default constants for the I/O handshake unit.
package io_pkg;

  localparam int unsigned DATA_W_DEF      = 32;
  localparam int unsigned SW_W_DEF        = 16;
  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned DEB_CYCLES_DEF  = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_PRESS,
    WAIT_RELEASE,
    HALTED
  } io_state_e;

  // Single command selected from the decoder lines after priority resolution.
  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_HLT,
    CMD_IN,
    CMD_OUT,
    CMD_SCAN
  } io_cmd_e;

  // Priority: halt, then in, then a qualified out, then scan.
  function automatic io_cmd_e decode_cmd(
    input logic hlt,
    input logic in_req,
    input logic output_enable,
    input logic not_out,
    input logic flagw
  );
    io_cmd_e cmd;
    cmd = CMD_NONE;
    if (hlt)                           cmd = CMD_HLT;
    else if (in_req)                   cmd = CMD_IN;
    else if (output_enable && !not_out) cmd = CMD_OUT;
    else if (flagw)                    cmd = CMD_SCAN;
    return cmd;
  endfunction

endpackage

// File: rtl/sync_debounce.sv
// Synchronizes the board switches and confirm button, then debounces the button.
module sync_debounce #(
  parameter int unsigned SW_W        = 16,
  parameter int unsigned SYNC_STAGES = 2,   // minimum 2
  parameter int unsigned DEB_CYCLES  = 4    // minimum 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [SW_W-1:0] sw_i,
  input  logic            btn_i,
  output logic [SW_W-1:0] sw_sync_o,
  output logic            btn_level_o
);

  localparam int unsigned CNT_W = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [SW_W-1:0]        sw_sync_q [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] btn_sync_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   btn_sync;

  assign btn_sync    = btn_sync_q[SYNC_STAGES-1];
  assign sw_sync_o   = sw_sync_q[SYNC_STAGES-1];
  assign btn_level_o = level_q;

  // Multi-flop synchronizer chains for the asynchronous board inputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sw_sync_q[i] <= '0;
      end
      btn_sync_q <= '0;
    end else begin
      sw_sync_q[0] <= sw_i;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sw_sync_q[i] <= sw_sync_q[i-1];
      end
      btn_sync_q <= {btn_sync_q[SYNC_STAGES-2:0], btn_i};
    end
  end

  // Count consecutive disagreeing samples; flip the level when the run is long enough.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (btn_sync != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = ~level_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/io_handshake_unit.sv
// Services the decoder's in/out/scan/halt requests against the board switches,
// confirm button and display register.
module io_handshake_unit
  import io_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned SW_W        = SW_W_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned DEB_CYCLES  = DEB_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inReq,
  input  logic              outputEnable,
  input  logic              notOUT,
  input  logic              flagw,
  input  logic              HLT,
  input  logic [DATA_W-1:0] regData,
  input  logic [SW_W-1:0]   switches,
  input  logic              confirmBtn,
  output logic              stall,
  output logic [DATA_W-1:0] inData,
  output logic              inValid,
  output logic [DATA_W-1:0] displayData,
  output logic              displayValid,
  output logic              scanFlag,
  output logic              halted
);

  logic [SW_W-1:0]   sw_sync;
  logic              btn_level;
  logic [DATA_W-1:0] sw_ext;
  io_cmd_e           cmd;
  logic              capture;
  logic              stall_c;

  io_state_e         state_q;
  logic [DATA_W-1:0] in_data_q;
  logic [DATA_W-1:0] disp_data_q;
  logic              disp_valid_q;
  logic              scan_flag_q;
  logic              halted_q;

  sync_debounce #(
    .SW_W        (SW_W),
    .SYNC_STAGES (SYNC_STAGES),
    .DEB_CYCLES  (DEB_CYCLES)
  ) u_sync_debounce (
    .clk_i       (clk),
    .rst_i       (reset),
    .sw_i        (switches),
    .btn_i       (confirmBtn),
    .sw_sync_o   (sw_sync),
    .btn_level_o (btn_level)
  );

  assign sw_ext  = DATA_W'(sw_sync);
  assign cmd     = decode_cmd(HLT, inReq, outputEnable, notOUT, flagw);
  assign capture = (state_q == WAIT_PRESS) && btn_level && !HLT;

  // Control FSM and the registered display/scan/halt outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      in_data_q    <= '0;
      disp_data_q  <= '0;
      disp_valid_q <= 1'b0;
      scan_flag_q  <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, WAIT_RELEASE: begin
          // A held in request in WAIT_RELEASE waits for the release, then
          // re-enters via IDLE so one press can only ever feed one capture.
          if (state_q == WAIT_RELEASE && !btn_level) begin
            state_q <= IDLE;
          end
          unique case (cmd)
            CMD_HLT: begin
              state_q  <= HALTED;
              halted_q <= 1'b1;
            end
            CMD_IN: begin
              if (state_q == IDLE) state_q <= WAIT_PRESS;
            end
            CMD_OUT: begin
              disp_data_q  <= regData;
              disp_valid_q <= 1'b1;
            end
            CMD_SCAN: scan_flag_q <= btn_level;
            default: ;
          endcase
        end
        WAIT_PRESS: begin
          if (HLT) begin
            state_q  <= HALTED;
            halted_q <= 1'b1;
          end else if (btn_level) begin
            in_data_q <= sw_ext;
            state_q   <= WAIT_RELEASE;
          end
        end
        HALTED: ;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Stall and capture strobe are combinational so the PC and register file
  // react in the same cycle; inData bypasses the register on the capture cycle.
  always_comb begin
    stall_c = 1'b0;
    inValid = 1'b0;
    inData  = in_data_q;
    unique case (state_q)
      IDLE, WAIT_RELEASE: stall_c = (cmd == CMD_IN);
      WAIT_PRESS: begin
        stall_c = !capture;
        inValid = capture;
        if (capture) inData = sw_ext;
      end
      HALTED: stall_c = 1'b1;
      default: stall_c = 1'b0;
    endcase
  end

  assign stall        = stall_c && !reset;
  assign displayData  = disp_data_q;
  assign displayValid = disp_valid_q;
  assign scanFlag     = scan_flag_q;
  assign halted       = halted_q;

endmodule

// File: tb/tb_io_handshake_unit.sv
// Directed bench for io_handshake_unit with a capture/display scoreboard.
module tb_io_handshake_unit;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned SW_W   = 16;
  localparam int unsigned SYNC   = 2;
  localparam int unsigned DEB    = 4;
  localparam int unsigned LAT    = SYNC + DEB;

  logic              clk = 1'b0;
  logic              reset;
  logic              inReq, outputEnable, notOUT, flagw, HLT, confirmBtn;
  logic [DATA_W-1:0] regData;
  logic [SW_W-1:0]   switches;
  logic              stall, inValid, displayValid, scanFlag, halted;
  logic [DATA_W-1:0] inData, displayData;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int inv_count = 0;

  logic [DATA_W-1:0] cap_q[$];
  logic [DATA_W-1:0] disp_q[$];
  logic [DATA_W-1:0] exp_disp;

  io_handshake_unit #(
    .DATA_W      (DATA_W),
    .SW_W        (SW_W),
    .SYNC_STAGES (SYNC),
    .DEB_CYCLES  (DEB)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .inReq        (inReq),
    .outputEnable (outputEnable),
    .notOUT       (notOUT),
    .flagw        (flagw),
    .HLT          (HLT),
    .regData      (regData),
    .switches     (switches),
    .confirmBtn   (confirmBtn),
    .stall        (stall),
    .inData       (inData),
    .inValid      (inValid),
    .displayData  (displayData),
    .displayValid (displayValid),
    .scanFlag     (scanFlag),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (inValid === 1'b1) inv_count++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for the inValid pulse, checks it against the capture scoreboard,
  // and drops inReq in the capture cycle.
  task automatic wait_capture(input string tag, input int max_edges, output int edges);
    bit stall_ok;
    stall_ok = 1'b1;
    edges = 0;
    while (edges < max_edges) begin
      tick();
      edges++;
      if (inValid === 1'b1) break;
      if (stall !== 1'b1) stall_ok = 1'b0;
    end
    chk({tag, "_stall_wait"}, stall_ok, 1'b1);
    chk({tag, "_seen"}, inValid, 1'b1);
    if (inValid === 1'b1) begin
      inReq = 1'b0;
      chk({tag, "_stall_cap"}, stall, 1'b0);
      if (cap_q.size() > 0) chk({tag, "_data"}, inData, cap_q.pop_front());
      else chk({tag, "_sb_nonempty"}, cap_q.size(), 1);
    end
  endtask

  initial begin
    int edges;
    int base;
    bit ok;

    reset = 1'b1; inReq = 0; outputEnable = 0; notOUT = 1; flagw = 0; HLT = 0;
    confirmBtn = 0; regData = '0; switches = '0; exp_disp = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_inValid", inValid, 0);
    chk("rst_inData", inData, 0);
    chk("rst_display", {displayValid, displayData}, 0);
    chk("rst_scan_halt", {scanFlag, halted}, 0);
    #2 reset = 1'b0;

    // in with a clean press 3 cycles after the request
    tick();
    switches = 16'hA5C3; inReq = 1'b1;
    cap_q.push_back(32'h0000A5C3);
    #1 chk("in1_stall_req", stall, 1);
    tick();
    inReq = 1'b0;
    tick(); tick();
    confirmBtn = 1'b1;
    base = inv_count;
    wait_capture("in1", 20, edges);
    chk("in1_latency", edges, LAT);
    tick();
    chk("in1_single_pulse", inValid, 0);
    chk("in1_no_stall_after", stall, 0);

    // back-to-back in with the button still held
    switches = 16'h0001; inReq = 1'b1;
    cap_q.push_back(32'h00000001);
    ok = 1'b1;
    repeat (8) begin
      tick();
      if (stall !== 1'b1) ok = 1'b0;
    end
    confirmBtn = 1'b0;
    repeat (LAT + 4) begin
      tick();
      if (stall !== 1'b1) ok = 1'b0;
    end
    chk("b2b_stall_held", ok, 1);
    chk("b2b_no_second_capture", inv_count - base, 1);
    confirmBtn = 1'b1;
    wait_capture("b2b", 20, edges);
    chk("b2b_latency", edges, LAT);
    confirmBtn = 1'b0;
    repeat (LAT + 3) tick();
    chk("b2b_total_captures", inv_count - base, 2);

    // bouncing button during WAIT_PRESS
    switches = 16'h1234; inReq = 1'b1;
    cap_q.push_back(32'h00001234);
    tick();
    inReq = 1'b0;
    base = inv_count;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      confirmBtn = ~confirmBtn;
      tick();
      if (stall !== 1'b1) ok = 1'b0;
    end
    chk("bounce_stall", ok, 1);
    chk("bounce_no_capture", inv_count - base, 0);
    confirmBtn = 1'b1;
    wait_capture("bounce", 20, edges);
    repeat (4) tick();
    chk("bounce_one_capture", inv_count - base, 1);
    confirmBtn = 1'b0;
    repeat (LAT + 3) tick();

    // out with notOUT low updates the display; with notOUT high it is ignored
    outputEnable = 1'b1; notOUT = 1'b0; regData = 32'hDEADBEEF;
    disp_q.push_back(32'hDEADBEEF);
    #1 chk("out_no_stall", stall, 0);
    tick();
    outputEnable = 1'b0; notOUT = 1'b1;
    exp_disp = disp_q.pop_front();
    chk("out_data", displayData, exp_disp);
    chk("out_valid", displayValid, 1);
    outputEnable = 1'b1; notOUT = 1'b1; regData = 32'h12345678;
    tick();
    outputEnable = 1'b0;
    chk("out_notout_ignored", displayData, exp_disp);

    // scan with button held, then released
    confirmBtn = 1'b1;
    repeat (LAT + 2) tick();
    flagw = 1'b1;
    tick();
    flagw = 1'b0;
    chk("scan_held", scanFlag, 1);
    confirmBtn = 1'b0;
    repeat (LAT + 2) tick();
    flagw = 1'b1;
    tick();
    flagw = 1'b0;
    chk("scan_released", scanFlag, 0);

    // inReq outranks a simultaneous out
    inReq = 1'b1; outputEnable = 1'b1; notOUT = 1'b0; regData = 32'hCAFEF00D;
    #1 chk("prio_stall_req", stall, 1);
    tick();
    inReq = 1'b0; outputEnable = 1'b0; notOUT = 1'b1;
    chk("prio_display_kept", displayData, exp_disp);
    chk("prio_in_wait", stall, 1);

    // halt while waiting for the press abandons the capture
    base = inv_count;
    HLT = 1'b1;
    #1 chk("hlt_no_valid", inValid, 0);
    tick();
    HLT = 1'b0;
    chk("hlt_halted", halted, 1);
    confirmBtn = 1'b1;
    repeat (LAT + 3) tick();
    outputEnable = 1'b1; notOUT = 1'b0; regData = 32'h11111111;
    tick();
    outputEnable = 1'b0; notOUT = 1'b1;
    chk("hlt_no_capture", inv_count - base, 0);
    chk("hlt_stall", {halted, stall}, 2'b11);
    chk("hlt_out_ignored", displayData, exp_disp);
    chk("sb_all_consumed", cap_q.size(), 0);

    // asynchronous reset between edges
    #2 reset = 1'b1;
    #1;
    chk("arst_stall", stall, 0);
    chk("arst_halted", halted, 0);
    chk("arst_display", {displayValid, displayData}, 0);
    chk("arst_in", {inValid, inData}, 0);
    chk("arst_scan", scanFlag, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
